// File: rtl/cntsched_pkg.sv
// Shared definitions for the countdown scheduler: FSM state type and the
// index-width helper used to size the winner/pointer registers.
package cntsched_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bits needed to index NREQ requesters (never less than one).
  function automatic int idx_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/countdown_sched_core.sv
// countdown_core: W-bit loadable down-counter that saturates at zero.
// Load has priority over enable; zero flags the terminal value.
module countdown_core #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] r_count;

  // Load a new interval, or step down by one; never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;
  assign zero  = (r_count == '0);

endmodule

// File: rtl/countdown_sched.sv
// countdown_sched: shares one countdown_core among NREQ requesters.
// IDLE picks a winner, LOAD seeds the counter with that requester's value,
// COUNT runs it to zero (pause holds, dropped req aborts), DONE pulses done.
// Build option: define CNTSCHED_RR_EN for round-robin arbitration; without
// it the lowest-index requester always wins and no pointer exists.
module countdown_sched
  import cntsched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] load_val,
  input  logic              pause,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [W-1:0]      count
);

  localparam int IDX_W = idx_w(NREQ);

  state_t             r_state;
  logic [IDX_W-1:0]   r_winner;
  logic [NREQ-1:0]    r_grant;
  logic [NREQ-1:0]    r_done;

  logic [W-1:0]       w_vals [NREQ];
  logic [W-1:0]       w_sel_val;
  logic               w_found;
  logic [IDX_W-1:0]   w_pick;
  logic [IDX_W-1:0]   w_pos;
  logic               w_load;
  logic               w_en;
  logic               w_zero;
  logic [W-1:0]       w_count;

`ifdef CNTSCHED_RR_EN
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W:0]     w_sum;
  logic [IDX_W-1:0]   w_ptr_next;

  // Pointer moves to the slot just after the finished/aborted owner.
  assign w_ptr_next = (r_winner == IDX_W'(NREQ - 1)) ? '0 : r_winner + 1'b1;
`endif

  // Split the flat load_val bus into per-requester slices.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_vals
      assign w_vals[gi] = load_val[gi*W +: W];
    end
  endgenerate

  assign w_sel_val = w_vals[r_winner];

  // Arbiter: first requesting slot in search order (rotated from the pointer
  // in round-robin builds, plain ascending otherwise).
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_pos   = '0;
`ifdef CNTSCHED_RR_EN
    w_sum   = '0;
`endif
    for (int k = 0; k < NREQ; k++) begin
`ifdef CNTSCHED_RR_EN
      w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NREQ)) begin
        w_sum = w_sum - (IDX_W+1)'(NREQ);
      end
      w_pos = w_sum[IDX_W-1:0];
`else
      w_pos = IDX_W'(k);
`endif
      if (!w_found && req[w_pos]) begin
        w_found = 1'b1;
        w_pick  = w_pos;
      end
    end
  end

  // Counter controls: seed in LOAD, decrement only while owner holds req
  // and pause is low (pause also wins over the zero check).
  assign w_load = (r_state == LOAD);
  assign w_en   = (r_state == COUNT) && req[r_winner] && !pause;

  countdown_core #(
    .W (W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_sel_val),
    .en       (w_en),
    .count    (w_count),
    .zero     (w_zero)
  );

  // Scheduler FSM with registered grant/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_winner <= '0;
      r_grant  <= '0;
      r_done   <= '0;
`ifdef CNTSCHED_RR_EN
      r_ptr    <= '0;
`endif
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_winner <= w_pick;
            r_grant  <= NREQ'(1) << w_pick;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          r_state <= COUNT;
        end
        COUNT: begin
          if (!req[r_winner]) begin
            // Abandoned: release silently, counter keeps its last value.
            r_grant <= '0;
            r_state <= IDLE;
`ifdef CNTSCHED_RR_EN
            r_ptr   <= w_ptr_next;
`endif
          end else if (pause) begin
            r_state <= COUNT;
          end else if (w_zero) begin
            r_done  <= NREQ'(1) << r_winner;
            r_grant <= '0;
            r_state <= DONE;
          end
        end
        DONE: begin
`ifdef CNTSCHED_RR_EN
          r_ptr   <= w_ptr_next;
`endif
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = (r_state != IDLE);
  assign count = w_count;

endmodule

// File: tb/tb_countdown_sched.sv
// Directed bench for countdown_sched (NREQ=4, W=4). Round-robin expectations
// are selected when CNTSCHED_RR_EN is defined for the compile.
module tb_countdown_sched;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] load_val;
  logic              pause;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [W-1:0]      count;

  logic [W-1:0]      lv [NREQ];

  int n_checks;
  int n_err;

  assign load_val = {lv[3], lv[2], lv[1], lv[0]};

  countdown_sched #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .load_val (load_val),
    .pause    (pause),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; sample/drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  logic [3:0] exp_g;

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    req      = '0;
    pause    = 1'b0;
    for (int i = 0; i < NREQ; i++) lv[i] = '0;

    // ---------------- reset state ----------------
    step(); step();
    rst = 1'b0;
    chk("rst_grant", grant, 0);
    chk("rst_done",  done,  0);
    chk("rst_busy",  busy,  0);
    chk("rst_count", count, 0);

    // ---------------- single request, v=3 ----------------
    req = 4'b0001; lv[0] = 4'd3;            // cycle 0
    chk("t1_c0_busy", busy, 0);
    step();                                  // c1
    chk("t1_c1_grant", grant, 4'b0001);
    chk("t1_c1_busy",  busy, 1);
    step(); chk("t1_c2_count", count, 3);
    step(); chk("t1_c3_count", count, 2);
    lv[0] = 4'd15;                           // ignored after LOAD
    step(); chk("t1_c4_count", count, 1);
    step(); chk("t1_c5_count", count, 0);
    chk("t1_c5_done", done, 0);
    step();                                  // c6
    chk("t1_c6_done",  done, 4'b0001);
    chk("t1_c6_grant", grant, 0);
    req = '0;
    step();                                  // c7
    chk("t1_c7_busy", busy, 0);
    chk("t1_c7_done", done, 0);

    // ---------------- zero interval ----------------
    req = 4'b0001; lv[0] = 4'd0;             // c0
    step(); chk("t2_c1_grant", grant, 4'b0001);
    step(); chk("t2_c2_count", count, 0);
    chk("t2_c2_done", done, 0);
    step(); chk("t2_c3_done", done, 4'b0001);
    chk("t2_c3_count", count, 0);
    req = '0;
    step(); chk("t2_c4_busy", busy, 0);

    // ---------------- arbitration, all requesting, v=1 ----------------
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) lv[i] = 4'd1;
    req = 4'b1111;                           // c0
    for (int g = 0; g < 5; g++) begin
`ifdef CNTSCHED_RR_EN
      exp_g = 4'b0001 << (g % 4);
`else
      exp_g = 4'b0001;
`endif
      step(); chk($sformatf("t3_grant%0d", g), grant, exp_g);
      step(); step();
      step(); chk($sformatf("t3_done%0d", g), done, exp_g);
      step(); chk($sformatf("t3_idle%0d", g), busy, 0);
    end
    req = '0;
    for (int i = 0; i < NREQ; i++) lv[i] = '0;

    // ---------------- pause, v=4 ----------------
    step();
    req = 4'b0001; lv[0] = 4'd4;             // c0
    step(); chk("t4_c1_grant", grant, 4'b0001);
    step(); chk("t4_c2_count", count, 4);
    step(); chk("t4_c3_count", count, 3);
    step(); chk("t4_c4_count", count, 2);
    pause = 1'b1;
    step(); chk("t4_c5_count", count, 2);
    step(); chk("t4_c6_count", count, 2);
    pause = 1'b0;
    step(); chk("t4_c7_count", count, 1);
    chk("t4_c7_done", done, 0);
    step(); chk("t4_c8_count", count, 0);
    pause = 1'b1;                            // pause beats zero
    step(); chk("t4_c9_done", done, 0);
    chk("t4_c9_count", count, 0);
    pause = 1'b0;
    step(); chk("t4_c10_done", done, 4'b0001);
    req = '0;
    step(); chk("t4_c11_busy", busy, 0);

    // ---------------- abort ----------------
    req = 4'b0110; lv[1] = 4'd7; lv[2] = 4'd2;   // c0
    step(); chk("t5_c1_grant", grant, 4'b0010);
    step(); chk("t5_c2_count", count, 7);
    step(); chk("t5_c3_count", count, 6);
    step(); chk("t5_c4_count", count, 5);
    req = 4'b0100;
    step();                                  // c5
    chk("t5_c5_grant", grant, 0);
    chk("t5_c5_busy",  busy, 0);
    chk("t5_c5_done",  done, 0);
    chk("t5_c5_count", count, 5);
    step(); chk("t5_c6_grant", grant, 4'b0100);
    step(); chk("t5_c7_count", count, 2);
    step(); step();
    chk("t5_c9_done", done, 0);
    step(); chk("t5_c10_done", done, 4'b0100);
    req = '0;
    step(); chk("t5_c11_busy", busy, 0);

    // ---------------- reset mid-count ----------------
    req = 4'b1000; lv[3] = 4'd9;             // c0
    step(); chk("t6_c1_grant", grant, 4'b1000);
    step(); step(); step(); step();          // c5
    chk("t6_c5_count", count, 6);
    rst = 1'b1;
    step();                                  // c6
    chk("t6_c6_grant", grant, 0);
    chk("t6_c6_done",  done, 0);
    chk("t6_c6_busy",  busy, 0);
    chk("t6_c6_count", count, 0);
    rst = 1'b0;
    req = 4'b1001;                           // pointer back at 0 -> slot 0
    step(); chk("t6_c7_grant", grant, 4'b0001);
    chk("t6_c7_done", done, 0);
    req = '0;
    step(); step();                          // owner abandons in COUNT
    chk("t6_c9_busy", busy, 0);
    chk("t6_c9_done", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_sched.md
# countdown_sched

Shared-interval scheduler that time-multiplexes one mod-n down-counter (`countdown_core`) among `NREQ` requesters. Each requester asks for a countdown of a programmable length; the block arbitrates, loads the winner's value, runs the count to zero, signals completion and moves on. It sits between request-generating control logic and the counter datapath. It replaces per-requester private counters.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `W`, default 4: counter width; max interval is 2^W−1.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  NREQ: per-requester request, level; held until `done` or abandoned.
- `load_val`  in  NREQ*W: per-requester start value; slice i = bits [i*W +: W].
- `pause`  in  1: freezes the count while high (COUNT state only).
- `grant`  out  NREQ: one-hot owner of the counter; registered.
- `done`  out  NREQ: one-cycle completion pulse to the owner; registered.
- `busy`  out  1: high whenever the state is not IDLE.
- `count`  out  W: current counter value.

## Operation
- FSM states:
  - IDLE: if any `req` bit is set, latch the winner index and go to LOAD. Otherwise stay.
  - LOAD: `count` ← `load_val[winner]`; `grant[winner]`=1; go to COUNT.
  - COUNT: if `req[winner]`=0, abort to IDLE. Else if `pause`, hold. Else if `count`==0, go to DONE. Else `count` ← `count`−1.
  - DONE: `done[winner]`=1 for this cycle; `grant`=0; advance arbitration pointer; go to IDLE.
- Abort behaviour:
  - Clears `grant`; no `done` pulse; pointer still advances; `count` holds its last value.
  - A requester dropping `req` in the LOAD cycle is not checked until the first COUNT cycle.
- Arbitration: per configuration; winner is decided only in IDLE.
- Sampling: `load_val` is sampled only in LOAD; later changes are ignored.
- Value 0 is legal: one COUNT cycle, then DONE.
- Wrap-around: the counter never wraps below 0; decrement is suppressed at 0.
- Simultaneous `pause` and `count`==0 in COUNT: pause wins (hold).
- A requester keeping `req` high after `done` is re-arbitrated as a fresh request.
- Reset mid-operation: state IDLE, pointer 0, and every output cleared. No `done` is emitted for the interrupted owner.

## Timing
- Reset values: `grant`=0, `done`=0, `busy`=0, `count`=0.
- Request seen in IDLE at cycle 0 → LOAD at cycle 1 (`grant`, `busy` high).
- COUNT runs from cycle 2 with `count`=v and reaches 0 at cycle 2+v, unpaused.
- DONE at cycle 3+v: `done` pulse, `grant` low. IDLE at cycle 4+v.
- Total occupancy is v+3 cycles, plus 1 IDLE cycle between grants; each pause cycle adds 1.

## Configuration
- `CNTSCHED_RR_EN` defined: round-robin arbitration.
  - Search starts at pointer p, ascending with wrap.
  - After DONE or abort, p ← winner+1 mod NREQ.
- Not defined: fixed priority, lowest index wins; the pointer logic is removed.

## Structure
- Shared package `cntsched_pkg`: state enum (IDLE, LOAD, COUNT, DONE), state encoding width, `IDX_W` = $clog2(NREQ) helper.
- Sub-module `countdown_core`: W-bit down-counter.
  - Inputs: `load`, `load_val`, `en`. Outputs: `count`, `zero`.
  - Saturates at 0; synchronous active-high reset to 0.
- FSM and arbiter stay in the top level.

## Test plan
- Single request: `req`=0001, `load_val[0]`=3 → `grant`=0001 at cycle 1; `count` 3,2,1,0 at cycles 2–5; `done`=0001 at cycle 6 only; `busy` low at cycle 7.
- Zero interval: `load_val`=0 → `done` at cycle 3; `count` stays 0.
- Round-robin (`CNTSCHED_RR_EN`): `req`=1111 held, all `load_val`=1 → grants in order 0,1,2,3,0. Without the macro: 0,0,0.
- Pause: `load_val`=4, `pause` high for 2 cycles at `count`=2 → `count` holds 2 for 2 cycles; `done` is delayed by 2 cycles.
- Abort: drop `req[1]` at `count`=5 → next cycle IDLE, `grant`=0, no `done`; `req[2]` is granted next.
- Reset mid-count: assert `rst` at `count`=6 → next cycle all outputs 0, IDLE, pointer 0; no `done` pulse.
